// File: rtl/writeback_unit_if.sv
// writeback_unit_if: pipeline-to-writeback bundle plus regfile write port and hazard outputs
interface writeback_unit_if #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 4,
  parameter int COUNTWIDTH   = 16
);
  logic                    in_valid;
  logic                    in_reg_write;
  logic                    in_is_load;
  logic [ADDRESSWIDTH-1:0] in_dest_address;
  logic [WIDTH-1:0]        in_alu_result;
  logic                    mem_read_valid;
  logic [WIDTH-1:0]        mem_read_data;
  logic                    flush;
  logic                    write_enable;
  logic [ADDRESSWIDTH-1:0] write_address;
  logic [WIDTH-1:0]        data_to_save;
  logic                    stall;
  logic                    load_pending_valid;
  logic [ADDRESSWIDTH-1:0] load_pending_address;
  logic                    load_error;
  logic [COUNTWIDTH-1:0]   retire_count;
  modport master (
    output in_valid, in_reg_write, in_is_load, in_dest_address, in_alu_result,
    output mem_read_valid, mem_read_data, flush,
    input  write_enable, write_address, data_to_save, stall,
    input  load_pending_valid, load_pending_address, load_error, retire_count
  );
  modport slave (
    input  in_valid, in_reg_write, in_is_load, in_dest_address, in_alu_result,
    input  mem_read_valid, mem_read_data, flush,
    output write_enable, write_address, data_to_save, stall,
    output load_pending_valid, load_pending_address, load_error, retire_count
  );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage; drives regfile writes and holds the pipe while a load is outstanding
module writeback_unit #(
  parameter int WIDTH        = 8,
  parameter int ADDRESSWIDTH = 4,
  parameter int PCADDRESS    = 15,
  parameter int MAXWAIT      = 15,
  parameter int COUNTWIDTH   = 16
) (
  input logic             clk,
  input logic             rst_n,
  writeback_unit_if.slave bus
);
  localparam int WW = $clog2(MAXWAIT + 1);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t                  state_q, state_d;
  logic [WW-1:0]           wait_cnt_q, wait_cnt_d;
  logic [ADDRESSWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                    pend_rw_q, pend_rw_d;
  logic                    write_enable_q, write_enable_d;
  logic [ADDRESSWIDTH-1:0] write_address_q, write_address_d;
  logic [WIDTH-1:0]        data_to_save_q, data_to_save_d;
  logic                    load_error_q, load_error_d;
  logic [COUNTWIDTH-1:0]   retire_count_q, retire_count_d;
  logic                    dest_ok, pend_ok;
  assign dest_ok = bus.in_dest_address != ADDRESSWIDTH'(PCADDRESS);
  assign pend_ok = pend_addr_q != ADDRESSWIDTH'(PCADDRESS);
  // Flush has priority over both load completion and a new accept.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    pend_addr_d     = pend_addr_q;
    pend_rw_d       = pend_rw_q;
    write_enable_d  = 1'b0;
    write_address_d = write_address_q;
    data_to_save_d  = data_to_save_q;
    load_error_d    = load_error_q;
    retire_count_d  = retire_count_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else if (state_q == WAIT_LOAD) begin
      if (bus.mem_read_valid) begin
        state_d         = IDLE;
        write_enable_d  = pend_rw_q && pend_ok;
        write_address_d = pend_addr_q;
        data_to_save_d  = bus.mem_read_data;
        retire_count_d  = retire_count_q + COUNTWIDTH'(1);
      end else if (wait_cnt_q == WW'(MAXWAIT - 1)) begin
        state_d      = IDLE;
        load_error_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WW'(1);
      end
    end else if (bus.in_valid) begin
      if (bus.in_is_load) begin
        state_d     = WAIT_LOAD;
        pend_addr_d = bus.in_dest_address;
        pend_rw_d   = bus.in_reg_write;
        wait_cnt_d  = '0;
      end else begin
        write_enable_d  = bus.in_reg_write && dest_ok;
        write_address_d = bus.in_dest_address;
        data_to_save_d  = bus.in_alu_result;
        retire_count_d  = retire_count_q + COUNTWIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wait_cnt_q      <= '0;
      pend_addr_q     <= '0;
      pend_rw_q       <= 1'b0;
      write_enable_q  <= 1'b0;
      write_address_q <= '0;
      data_to_save_q  <= '0;
      load_error_q    <= 1'b0;
      retire_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      wait_cnt_q      <= wait_cnt_d;
      pend_addr_q     <= pend_addr_d;
      pend_rw_q       <= pend_rw_d;
      write_enable_q  <= write_enable_d;
      write_address_q <= write_address_d;
      data_to_save_q  <= data_to_save_d;
      load_error_q    <= load_error_d;
      retire_count_q  <= retire_count_d;
    end
  end
  assign bus.write_enable         = write_enable_q;
  assign bus.write_address        = write_address_q;
  assign bus.data_to_save         = data_to_save_q;
  assign bus.stall                = state_q == WAIT_LOAD;
  assign bus.load_pending_valid   = state_q == WAIT_LOAD;
  assign bus.load_pending_address = pend_addr_q;
  assign bus.load_error           = load_error_q;
  assign bus.retire_count         = retire_count_q;
endmodule
